// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: entry layout and result select.
package wb_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [DATA_W-1:0] wb_select(input logic              mem_to_reg,
                                                    input logic [DATA_W-1:0] alu,
                                                    input logic [DATA_W-1:0] mem);
        return mem_to_reg ? mem : alu;
    endfunction
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of writeback entries; exposes both entries in age order for bypass lookup.
module wb_fifo2
    import wb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  wb_entry_t             entry_i,
    output logic [1:0]            count_o,
    output wb_entry_t [1:0]       ent_o,
    output logic [1:0]            vld_o
);
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    wb_entry_t   mem_q [2];
    logic        do_push, do_pop;

    // Pop is gated on occupancy, so an empty queue never passes an entry straight through.
    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i  && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (do_push) begin
            tail_d = ~tail_q;
        end
        if (do_pop) begin
            head_d = ~head_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (do_push) begin
                mem_q[tail_q] <= entry_i;
            end
        end
    end

    assign count_o = count_q;

    // Slot 0 is the head (oldest), slot 1 the entry behind it (youngest when full).
    for (genvar gi = 0; gi < 2; gi++) begin : g_age
        assign ent_o[gi] = mem_q[head_q ^ 1'(gi)];
        assign vld_o[gi] = (count_q > 2'(gi));
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers MEM results, drains them to the register file, offers bypass lookup.
module wb_stage
    import wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_reg_write_i,
    input  logic              in_mem_to_reg_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic [DATA_W-1:0] in_alu_result_i,
    input  logic [DATA_W-1:0] in_mem_data_i,
    input  logic              wb_hold_i,
    output logic [ADDR_W-1:0] write_reg_o,
    output logic [DATA_W-1:0] write_reg_data_o,
    output logic              reg_write_o,
    input  logic [ADDR_W-1:0] lookup_rs_i,
    output logic              lookup_hit_o,
    output logic [DATA_W-1:0] lookup_data_o,
    output logic [CNT_W-1:0]  retire_count_o
);
    wb_entry_t        new_entry;
    wb_entry_t [1:0]  ent;
    logic [1:0]       vld;
    logic [1:0]       hit;
    logic [1:0]       count;
    logic             push, pop;
    logic [CNT_W-1:0] retire_q, retire_d;

    // x0 writes are dropped here so nothing downstream has to special-case them.
    assign new_entry.we   = in_reg_write_i && (in_rd_i != '0);
    assign new_entry.rd   = in_rd_i;
    assign new_entry.data = wb_select(in_mem_to_reg_i, in_alu_result_i, in_mem_data_i);

    assign in_ready_o = (count != 2'd2);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (count != 2'd0) && !wb_hold_i;

    wb_fifo2 u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (new_entry),
        .count_o (count),
        .ent_o   (ent),
        .vld_o   (vld)
    );

    assign reg_write_o      = vld[0] && ent[0].we && !wb_hold_i;
    assign write_reg_o      = vld[0] ? ent[0].rd   : '0;
    assign write_reg_data_o = vld[0] ? ent[0].data : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
        assign hit[gi] = vld[gi] && ent[gi].we && (ent[gi].rd == lookup_rs_i) && (lookup_rs_i != '0);
    end

    // Younger entry shadows the head, matching the order the register file will see them.
    assign lookup_hit_o  = |hit;
    assign lookup_data_o = hit[1] ? ent[1].data : (hit[0] ? ent[0].data : '0);

    assign retire_d = pop ? retire_q + 1'b1 : retire_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count_o = retire_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomised and directed bench for wb_stage against a queue-based reference model.
module tb_wb_stage;
    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, in_reg_write, in_mem_to_reg;
    logic [4:0] in_rd;
    logic [7:0] in_alu, in_mem;
    logic       wb_hold;
    logic [4:0] write_reg;
    logic [7:0] write_data;
    logic       reg_write;
    logic [4:0] lookup_rs;
    logic       lookup_hit;
    logic [7:0] lookup_data;
    logic [15:0] retire_count;

    wb_stage dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_reg_write_i   (in_reg_write),
        .in_mem_to_reg_i  (in_mem_to_reg),
        .in_rd_i          (in_rd),
        .in_alu_result_i  (in_alu),
        .in_mem_data_i    (in_mem),
        .wb_hold_i        (wb_hold),
        .write_reg_o      (write_reg),
        .write_reg_data_o (write_data),
        .reg_write_o      (reg_write),
        .lookup_rs_i      (lookup_rs),
        .lookup_hit_o     (lookup_hit),
        .lookup_data_o    (lookup_data),
        .retire_count_o   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       we;
        bit [4:0] rd;
        bit [7:0] data;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_retire;
    int          n_checks;
    int          n_errors;
    bit          verbose;

    // Outputs observed during the most recent step, for directed checks.
    logic       obs_ready, obs_rw, obs_hit;
    logic [4:0] obs_wr;
    logic [7:0] obs_wd, obs_ld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit we, input bit m2r, input logic [4:0] rd,
                        input logic [7:0] alu, input logic [7:0] mem, input bit hold,
                        input logic [4:0] rs);
        bit       e_ready, e_rw, e_hit, acc, drain;
        bit [4:0] e_wr;
        bit [7:0] e_wd, e_ld;
        ent_t     ne;
        @(negedge clk);
        in_valid = v; in_reg_write = we; in_mem_to_reg = m2r; in_rd = rd;
        in_alu = alu; in_mem = mem; wb_hold = hold; lookup_rs = rs;
        #1;
        e_ready = (mq.size() < 2);
        e_rw = 1'b0; e_wr = '0; e_wd = '0;
        if (mq.size() > 0) begin
            e_rw = mq[0].we && !hold;
            e_wr = mq[0].rd;
            e_wd = mq[0].data;
        end
        e_hit = 1'b0; e_ld = '0;
        if (rs != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!e_hit && mq[i].we && mq[i].rd == rs) begin
                    e_hit = 1'b1;
                    e_ld  = mq[i].data;
                end
            end
        end
        obs_ready = in_ready; obs_rw = reg_write; obs_wr = write_reg;
        obs_wd = write_data; obs_hit = lookup_hit; obs_ld = lookup_data;
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("reg_write", 32'(reg_write), 32'(e_rw));
        check("write_reg", 32'(write_reg), 32'(e_wr));
        check("write_data", 32'(write_data), 32'(e_wd));
        check("lookup_hit", 32'(lookup_hit), 32'(e_hit));
        check("lookup_data", 32'(lookup_data), 32'(e_ld));
        check("retire_count", 32'(retire_count), m_retire);
        if (verbose)
            $display("txn v=%0b rd=%0d hold=%0b rs=%0d | rdy=%0b we=%0b wr=%0d wd=%02h hit=%0b ld=%02h ret=%0d",
                     v, rd, hold, rs, in_ready, reg_write, write_reg, write_data,
                     lookup_hit, lookup_data, retire_count);
        acc   = v && e_ready;
        drain = (mq.size() > 0) && !hold;
        @(posedge clk);
        if (drain) begin
            void'(mq.pop_front());
            m_retire = (m_retire + 1) % 65536;
        end
        if (acc) begin
            ne.we   = we && (rd != 0);
            ne.rd   = rd;
            ne.data = m2r ? mem : alu;
            mq.push_back(ne);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        mq.delete();
        m_retire = 0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_rw", 32'(reg_write), 32'd0);
        check("rst_wr", 32'(write_reg), 32'd0);
        check("rst_retire", 32'(retire_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_nocapture", 32'(reg_write) | 32'(write_reg), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_retire = 0; verbose = 1'b1;
        rst_n = 1'b0; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_rd = 0; in_alu = 0; in_mem = 0; wb_hold = 0; lookup_rs = 0;
        repeat (2) @(posedge clk);
        #1;
        check("init_ready", 32'(in_ready), 32'd1);
        check("init_rw", 32'(reg_write), 32'd0);
        check("init_hit", 32'(lookup_hit), 32'd0);
        check("init_ld", 32'(lookup_data), 32'd0);
        check("init_retire", 32'(retire_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write
        step(1, 1, 0, 5'd5, 8'h3C, 8'h00, 0, 5'd0);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 0, 5'd5);
        check("basic_rw", 32'(obs_rw), 32'd1);
        check("basic_wr", 32'(obs_wr), 32'd5);
        check("basic_wd", 32'(obs_wd), 32'h3C);
        check("basic_bypass", 32'(obs_ld), 32'h3C);
        #1 check("basic_retire", 32'(retire_count), 32'd1);

        // Memory select, then x0 write
        step(1, 1, 1, 5'd7, 8'h11, 8'hA5, 0, 5'd0);
        step(1, 1, 0, 5'd0, 8'h55, 8'h00, 0, 5'd0);
        check("memsel_wd", 32'(obs_wd), 32'hA5);
        check("memsel_wr", 32'(obs_wr), 32'd7);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 0, 5'd0);
        check("x0_rw", 32'(obs_rw), 32'd0);
        #1 check("x0_retire", 32'(retire_count), 32'd3);

        // Backpressure
        step(1, 1, 0, 5'd1, 8'h01, 8'h00, 1, 5'd0);
        check("bp_ready1", 32'(obs_ready), 32'd1);
        step(1, 1, 0, 5'd2, 8'h02, 8'h00, 1, 5'd0);
        check("bp_ready2", 32'(obs_ready), 32'd1);
        step(1, 1, 0, 5'd3, 8'h03, 8'h00, 1, 5'd0);
        check("bp_ready3", 32'(obs_ready), 32'd0);
        step(1, 1, 0, 5'd3, 8'h03, 8'h00, 0, 5'd0);
        check("bp_drain1", {obs_rw, 3'b0, obs_wr}, {1'b1, 3'b0, 5'd1});
        step(1, 1, 0, 5'd3, 8'h03, 8'h00, 0, 5'd0);
        check("bp_drain2", {obs_rw, 3'b0, obs_wr}, {1'b1, 3'b0, 5'd2});
        check("bp_ready_up", 32'(obs_ready), 32'd1);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 0, 5'd0);
        check("bp_drain3", {obs_rw, 3'b0, obs_wr}, {1'b1, 3'b0, 5'd3});

        // Bypass priority
        step(1, 1, 0, 5'd3, 8'h10, 8'h00, 1, 5'd3);
        step(1, 1, 0, 5'd3, 8'h20, 8'h00, 1, 5'd3);
        check("byp_one", 32'(obs_ld), 32'h10);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 1, 5'd3);
        check("byp_young_hit", 32'(obs_hit), 32'd1);
        check("byp_young_data", 32'(obs_ld), 32'h20);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 1, 5'd0);
        check("byp_x0", 32'(obs_hit), 32'd0);
        step(0, 0, 0, 5'd0, 8'h00, 8'h00, 1, 5'd4);
        check("byp_miss", 32'(obs_hit), 32'd0);

        // Reset mid-operation with two entries queued
        @(negedge clk);
        wb_hold = 1'b0;
        #1 check("pre_rst_rw", 32'(reg_write), 32'd1);
        rst_n = 1'b0;
        #1 check("mid_rst_rw", 32'(reg_write), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 5'd0, 8'h00, 8'h00, 0, 5'd3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
        end

        // Counter wrap: 65536 dequeues from reset
        do_reset();
        verbose = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            step(1, 1'($urandom), 0, 5'($urandom), 8'($urandom), 8'h00, 0, 5'($urandom));
        end
        #1 check("wrap_retire", 32'(retire_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 8-bit RISC-V pipeline: the write-side counterpart to the decode stage's register-file read port. It accepts resolved MEM-stage results over a valid/ready handshake and buffers them in a 2-entry queue. It drains them, one per cycle, onto the register file's write port. It also exposes a bypass lookup so decode can obtain values that are queued but not yet written.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 5, register index width
- CNT_W, 16, retire counter width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM stage presents a result
- in_ready  out  1  stage can accept a result this cycle
- in_reg_write  in  1  result writes a register
- in_mem_to_reg  in  1  1: select in_mem_data, 0: select in_alu_result
- in_rd  in  ADDR_W  destination register
- in_alu_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  data-memory read data
- wb_hold  in  1  register-file write port unavailable this cycle
- write_reg  out  ADDR_W  register-file write index
- write_reg_data  out  DATA_W  register-file write data
- reg_write  out  1  register-file write enable
- lookup_rs  in  ADDR_W  decode source register to bypass-check
- lookup_hit  out  1  a queued, unwritten entry targets lookup_rs
- lookup_data  out  DATA_W  data of the youngest matching entry
- retire_count  out  CNT_W  number of entries drained since reset

## Operation
- Entry = {we, rd, data}.
  - data = in_mem_to_reg ? in_mem_data : in_alu_result, resolved at enqueue.
  - we = in_reg_write && (in_rd != 0). Writes to x0 are neutralised at enqueue.
- Queue: 2 entries, FIFO order, occupancy count 0..2, head/tail pointers 1 bit each and wrapping.
- in_ready = (count != 2). It is combinational from registered count only and never depends on in_valid or wb_hold.
- Enqueue: in_valid && in_ready at a rising edge.
- Dequeue: count != 0 && !wb_hold at a rising edge. Entries with we=0 still dequeue and still retire.
- Write port, combinational from head:
  - reg_write = (count != 0) && head.we && !wb_hold.
  - write_reg = head.rd and write_reg_data = head.data when count != 0; both are 0 when empty.
- Simultaneous enqueue and dequeue:
  - Allowed at count 1; count stays 1.
  - At count 0, only enqueue happens; no pass-through.
  - At count 2, in_ready=0, so only dequeue happens.
- Bypass lookup, combinational:
  - Compare lookup_rs against every valid entry with we=1.
  - Youngest match wins (tail-side entry over head).
  - lookup_rs == 0 never hits.
  - With no hit, lookup_hit=0 and lookup_data=0.
  - An entry being written this cycle still hits, because the register file updates at the edge.
- retire_count increments by 1 per dequeue and wraps from 2^CNT_W-1 to 0.
- Reset values while asserted:
  - count=0 and pointers=0; queue storage cleared.
  - retire_count=0, reg_write=0, write_reg=0, write_reg_data=0, lookup_hit=0, lookup_data=0.
  - in_ready=1 (count=0), but no enqueue is captured while reset is low.
- Reset mid-operation discards all queued entries immediately (asynchronous). No partial write occurs after reset assertion.

## Timing
- Latency: an entry enqueued at edge N appears on the write port during cycle N+1. Its register is updated at edge N+1 if wb_hold=0.
- Sustained throughput is 1 entry per cycle with wb_hold=0.
- wb_hold held for k cycles freezes the head.
  - The queue fills after at most 2 enqueues; in_ready then drops in the following cycle.
  - On wb_hold release, drain proceeds one entry per cycle in FIFO order.
- The lookup path and the write-port outputs are purely combinational from registered state plus wb_hold and lookup_rs. There is no path from in_* to any output.
- Reset deassertion: the first enqueue can occur at the first rising edge after reset goes high.

## Structure
- Package wb_pkg:
  - DATA_W and ADDR_W constants.
  - Typedef wb_entry_t {we, rd, data}.
  - Function wb_select(mem_to_reg, alu, mem) returning data.
- Sub-module wb_fifo2: the 2-entry queue holding wb_entry_t. It provides count, head read, per-entry valid, and entry contents for the lookup.
- The top level holds the select and x0 neutralisation, write-port drive, lookup priority mux, and retire counter.

## Test plan
- Basic write: enqueue {reg_write=1, mem_to_reg=0, rd=5, alu=8'h3C} with wb_hold=0 → next cycle reg_write=1, write_reg=5, write_reg_data=8'h3C; retire_count goes 0→1.
- Memory select and x0 write:
  - Enqueue {mem_to_reg=1, rd=7, mem=8'hA5, alu=8'h11} → write_reg_data=8'hA5.
  - Enqueue rd=0 with reg_write=1 → reg_write stays 0, yet retire_count still increments.
- Backpressure: wb_hold=1 while 3 results are offered back-to-back → first two accepted, in_ready=0 for the third. Release wb_hold → writes occur on 3 consecutive cycles in order, with in_ready rising again.
- Bypass priority: queue holds rd=3 (8'h10, head) and rd=3 (8'h20, tail), and lookup_rs=3 → lookup_hit=1, lookup_data=8'h20. With lookup_rs=0 or 4 → lookup_hit=0.
- Reset mid-operation: with 2 entries queued and wb_hold=1, assert reset → count=0, reg_write=0 immediately. After release, the old entries never appear on the write port.
- Counter wrap: force 65536 dequeues → retire_count returns to 0.
